// File: rtl/pwm_bank_pkg.sv
// pwm_bank_pkg: shared constants for the PWM bank (duty ramping is enabled by PWM_BANK_RAMP_EN)
package pwm_bank_pkg;

    localparam int ADDR_W         = 6;
    localparam int PERIOD_RST_DEF = 2499;
    localparam int RAMP_STEP_DEF  = 16;

    // The period register sits directly after the last channel duty register.
    function automatic logic [ADDR_W-1:0] period_addr(input int n_ch);
        return ADDR_W'(n_ch);
    endfunction

endpackage

// File: rtl/pwm_bank_ch.sv
// pwm_bank_ch: one PWM channel (shadow/active duty, optional ramp under PWM_BANK_RAMP_EN, compare flop)
module pwm_bank_ch
    import pwm_bank_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int RAMP_STEP = RAMP_STEP_DEF
) (
    input  logic             clk50M,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [CNT_W-1:0] wdata_i,
    input  logic             wrap_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             pwm_o
);

`ifdef PWM_BANK_RAMP_EN
    localparam bit RAMP_EN = 1'b1;
`else
    localparam bit RAMP_EN = 1'b0;
`endif
    localparam logic [CNT_W-1:0] STEP = CNT_W'(RAMP_STEP);

    logic [CNT_W-1:0] sh_q, act_q, act_d, ramp;
    logic             pwm_q;

    // Active duty follows the shadow at each wrap, either directly or limited to STEP without overshoot.
    always_comb begin
        ramp  = (sh_q > act_q) ? ((sh_q - act_q > STEP) ? act_q + STEP : sh_q)
                               : ((act_q - sh_q > STEP) ? act_q - STEP : sh_q);
        act_d = wrap_i ? (RAMP_EN ? ramp : sh_q) : act_q;
    end

    // Shadow capture, active update and registered compare against the active duty.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            act_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            if (we_i) sh_q <= wdata_i;
            act_q <= act_d;
            pwm_q <= cnt_i < act_q;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: bank of N_CH shadow-buffered PWM channels sharing one counter (ramping via PWM_BANK_RAMP_EN)
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int N_CH       = 10,
    parameter int CNT_W      = 16,
    parameter int PERIOD_RST = PERIOD_RST_DEF,
    parameter int RAMP_STEP  = RAMP_STEP_DEF
) (
    input  logic              clk50M,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CNT_W-1:0]  wr_data,
    output logic              wr_err,
    output logic [N_CH-1:0]   pwm_out,
    output logic              period_tick
);

    localparam logic [ADDR_W-1:0] PER_ADDR = period_addr(N_CH);
    localparam logic [CNT_W-1:0]  PER_RST  = CNT_W'(PERIOD_RST);

    logic [CNT_W-1:0] cnt_q, cnt_d, per_sh_q, per_sh_d, per_act_q, per_act_d;
    logic             wrap, wrap_q, tick_q, err_q;

    // Wrap detection, counter advance and period shadow/active selection.
    always_comb begin
        wrap      = cnt_q == per_act_q;
        cnt_d     = wrap ? '0 : cnt_q + 1'b1;
        per_sh_d  = (wr_en && wr_addr == PER_ADDR) ? wr_data : per_sh_q;
        per_act_d = wrap ? per_sh_q : per_act_q;
    end

    // Counter, period registers; tick is delayed two cycles so it lines up with the first output of a period.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            per_sh_q  <= PER_RST;
            per_act_q <= PER_RST;
            wrap_q    <= 1'b0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            per_sh_q  <= per_sh_d;
            per_act_q <= per_act_d;
            wrap_q    <= wrap;
            tick_q    <= wrap_q;
            err_q     <= wr_en && wr_addr > PER_ADDR;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pwm_bank_ch #(.CNT_W(CNT_W), .RAMP_STEP(RAMP_STEP)) u_ch (
            .clk50M (clk50M),
            .rst_n  (rst_n),
            .we_i   (wr_en && wr_addr == ADDR_W'(i)),
            .wdata_i(wr_data),
            .wrap_i (wrap),
            .cnt_i  (cnt_q),
            .pwm_o  (pwm_out[i])
        );
    end

    assign wr_err      = err_q;
    assign period_tick = tick_q;

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter N_CH, default 10, number of PWM channels (1..32).
REQ-002 Parameter CNT_W, default 16, width of counter, period and duty values.
REQ-003 Parameter PERIOD_RST, default 2499, period register reset value (20 kHz at 50 MHz).
REQ-004 Parameter RAMP_STEP, default 16, maximum duty change per PWM period when ramping is compiled in.
REQ-005 The block SHALL have the port clk50M, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-006 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have the port wr_en, input, 1 bit: register write strobe, one write per high cycle.
REQ-008 The block SHALL have the port wr_addr, input, 6 bits: address 0..N_CH-1 selects a channel duty register; address N_CH selects the period register.
REQ-009 The block SHALL have the port wr_data, input, CNT_W bits: value to write.
REQ-010 The block SHALL have the port wr_err, output, 1 bit: one-cycle pulse on a write to an address greater than N_CH.
REQ-011 The block SHALL have the port pwm_out, output, N_CH bits: registered PWM outputs, bit i is channel i.
REQ-012 The block SHALL have the port period_tick, output, 1 bit: one-cycle pulse on the cycle the counter wraps to 0.

Function
REQ-013 The counter SHALL count 0..period_act and then wrap to 0; period_act is the active period.
REQ-014 Each channel SHALL have a shadow duty register, written by wr_en, and an active duty register.
REQ-015 The period SHALL likewise have a shadow register and an active register.
REQ-016 All active registers SHALL load from their shadows only on the wrap cycle (counter == period_act), giving glitch-free updates.
REQ-017 A write that lands on the wrap cycle SHALL update its shadow; the active register takes the pre-write shadow value, and the new value applies one period later.
REQ-018 pwm_out[i] SHALL be registered high in the cycle after the counter holds cnt, when cnt < duty_act[i], and low otherwise; the latency is 1 clock.
REQ-019 Channel duty boundaries:
- duty 0: output constant low.
- duty > period_act: output constant high, no glitch at wrap.
REQ-020 period_act == 0: every cycle SHALL be a wrap; period_tick is held high continuously; output is high only if duty > 0.
REQ-021 A write to an address greater than N_CH SHALL be ignored, with wr_err pulsing high in the following cycle.
REQ-022 period_tick SHALL be registered and aligned with the first pwm_out cycle of the new period.

Reset
REQ-023 Asserting rst_n low SHALL asynchronously clear the following to 0: counter, all shadow and active duty registers, pwm_out, period_tick and wr_err.
REQ-024 Asserting rst_n low SHALL asynchronously load the shadow and active period registers with PERIOD_RST.
REQ-025 Reset mid-period SHALL drop all outputs low immediately; after release, counting restarts from 0 on the first clock edge.

Configuration
REQ-026 With macro PWM_BANK_RAMP_EN defined, each active duty SHALL move toward its shadow by at most RAMP_STEP per wrap, saturating exactly at the shadow value without overshoot.
REQ-027 Without PWM_BANK_RAMP_EN, the active duty SHALL jump directly to the shadow value at each wrap.
REQ-028 The period SHALL never be ramped, with or without PWM_BANK_RAMP_EN.

Structure
REQ-029 Package pwm_bank_pkg SHALL hold the following:
- the address-width constant (6);
- the period-register address offset rule;
- the PERIOD_RST and RAMP_STEP defaults.
REQ-030 Sub-module pwm_bank_ch, instantiated N_CH times, SHALL hold one channel's shadow register, active register, ramp logic and compare flop.
REQ-031 The counter, period registers, address decode and wr_err SHALL reside in the top level.

Verification
REQ-032 Scenario: N_CH=10, period 99, write duty 25 to channel 3 -> from the period after the next wrap, pwm_out[3] is high 25 of every 100 cycles and period_tick fires every 100 cycles.
REQ-033 Scenario: duty 0 on channel 0 and duty 200 on channel 1 with period 99 -> pwm_out[0] is never high and pwm_out[1] is never low across 3 periods.
REQ-034 Scenario: write period 49 mid-period at count 70 -> the current period still ends at 99, and the next period is 50 cycles.
REQ-035 Scenario: write address 11 with N_CH=10 -> wr_err pulses for 1 cycle and no register changes.
REQ-036 Scenario: with PWM_BANK_RAMP_EN, RAMP_STEP 16, duty written 0 -> 40 -> the active duty goes 16, 32, 40 over three successive wraps.
REQ-037 Scenario: assert rst_n at count 57 with outputs high -> pwm_out is 0 without waiting for a clock, and the period equals PERIOD_RST after release.
